alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequential issue/decode stage that drives the ALU's 5-bit operation interface. It accepts a 32-bit MIPS instruction plus register-file operands through a valid/ready handshake, decodes it into the ALU op code and operand pair, and holds those values on registered outputs for one execute cycle. It then captures the ALU's result and zero flag and presents them downstream under a second valid/ready handshake. It sits between register read and write-back/branch logic in the single-cycle datapath's ALU slot.

## Interface
- No parameters; data width is fixed at 32 bits and op code width at 5 bits.
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-low reset
- in_valid_i  in  1  instruction/operands valid
- in_ready_o  out  1  stage can accept; equals (state==IDLE)
- instr_i  in  32  MIPS instruction word
- rs_data_i  in  32  register rs value
- rt_data_i  in  32  register rt value
- alu_src1_o  out  32  registered ALU operand 1
- alu_src2_o  out  32  registered ALU operand 2
- alu_ctrl_o  out  5  registered ALU op code
- alu_result_i  in  32  ALU result (combinational from alu_* outputs)
- alu_zero_i  in  1  ALU condition flag
- out_valid_o  out  1  captured result valid
- out_ready_i  in  1  downstream accepts
- out_result_o  out  32  captured result
- out_zero_o  out  1  captured condition flag (branch taken for EQUA/NEQU/BIG)
- out_ctrl_o  out  5  op code that produced the result
- out_illegal_o  out  1  instruction did not decode

## Operation
- ALU op codes: NOTH=0, ADD=1, ADDU=2, SUB=3, AND=4, OR=5, XOR=6, NOR=7, NAND=8, SMAL=9, LEFT=10, RIGH=11, RS=12, EQUA=13, NEQU=14, BIG=15, JTYP=16, LUI=17.
- R-type (opcode 0x00), by funct: 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SMAL; src1=rs, src2=rt.
- Shifts: funct 0x00 LEFT, 0x02 RIGH; src1=rt, src2={27'b0, shamt}.
- funct 0x08 (jr): RS, src1=rs, src2=0.
- I-type: 0x08 ADD, 0x09 ADDU, 0x0A SMAL, 0x23/0x2B ADD; src1=rs, src2=sign-extended imm16.
- 0x0C AND and 0x0D OR: src2=zero-extended imm16.
- 0x0F LUI: src1=0, src2=zero-extended imm16; the ALU performs the shift.
- 0x04 EQUA, 0x05 NEQU: src1=rs, src2=rt.
- 0x07 BIG: src1=rs, src2=0.
- 0x02/0x03 JTYP: both operands 0.
- Any other opcode/funct: alu_ctrl_o=NOTH, operands 0, illegal flag set.
- FSM states and transitions:
  - IDLE: in_ready_o=1; on in_valid_i, register the decoded ctrl/operands/illegal flag and go to EXEC.
  - EXEC: one cycle; the ALU evaluates. At the closing edge, capture result/zero and go to HOLD.
  - HOLD: out_valid_o=1; outputs stable until out_ready_i is sampled high, then go to IDLE.
- NOTH/illegal capture: out_result_o=0 and out_zero_o=0 are forced regardless of alu_result_i/alu_zero_i, because the ALU holds its stale value for NOTH.
- alu_* outputs hold their last issued values in HOLD and IDLE; they change only on acceptance.

## Timing
- Reset values: state=IDLE, in_ready_o=1, out_valid_o=0; alu_src1_o, alu_src2_o, alu_ctrl_o, out_result_o, out_ctrl_o=0; out_zero_o=0, out_illegal_o=0.
- Inputs are ignored while rst_i is low.
- Acceptance at edge k gives: alu_* valid in cycle k+1, out_valid_o=1 from cycle k+2.
- Latency is 2 cycles from accept to out_valid_o; minimum initiation interval is 3 cycles (out_ready_i held high).
- in_valid_i in EXEC/HOLD is not accepted (in_ready_o=0); the upstream holds instr_i and operands.
- out_ready_i outside HOLD has no effect. out_valid_o must not drop without a transfer.
- Reset mid-operation (EXEC or HOLD) drops the in-flight op; all outputs return to reset values asynchronously.
- Arithmetic is done only in the ALU; this block performs only extension and field selection.

## Test plan
- Reset, then add $rs=5, $rt=7 (instr 0x00851020) -> alu_ctrl_o=1 in cycle k+1; out_valid_o=1 at k+2 with out_result_o=12, out_zero_o=0.
- addi with imm 0xFFFF and rs=3 -> alu_src2_o=0xFFFFFFFF, result 2. ori with imm 0xFFFF and rs=0 -> alu_src2_o=0x0000FFFF, result 0x0000FFFF.
- beq with rs=rt=9 -> out_ctrl_o=13, out_zero_o=1. bne with the same operands -> out_zero_o=0. bgtz with rs=-1 -> out_zero_o=0.
- sll shamt=4, rt=1 -> src1=1, src2=4, result 16. lui imm 0x1234 -> result 0x12340000.
- Illegal opcode 0x3F issued after a valid add -> out_illegal_o=1, out_result_o=0, out_ctrl_o=0.
- out_ready_i held low for 5 HOLD cycles, then rst_i pulsed low in a later EXEC -> outputs stable with in_ready_o=0 throughout HOLD; after reset, out_valid_o=0 and in_ready_o=1 with all outputs zero.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if
// Bundles every signal between the ALU issue stage and its neighbours:
//   - upstream handshake:   in_valid_i, in_ready_o, instr_i, rs_data_i, rt_data_i
//   - ALU operation bus:    alu_src1_o, alu_src2_o, alu_ctrl_o, alu_result_i, alu_zero_i
//   - downstream handshake: out_valid_o, out_ready_i, out_result_o, out_zero_o,
//                           out_ctrl_o, out_illegal_o
// The _i/_o suffixes are from the issue stage's point of view.
// The slave modport is the issue stage itself.
// The master modport is everything around it: register read, the ALU and write-back.
interface alu_issue_ctrl_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic [31:0] rs_data_i;
  logic [31:0] rt_data_i;

  logic [31:0] alu_src1_o;
  logic [31:0] alu_src2_o;
  logic [4:0]  alu_ctrl_o;
  logic [31:0] alu_result_i;
  logic        alu_zero_i;

  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_result_o;
  logic        out_zero_o;
  logic [4:0]  out_ctrl_o;
  logic        out_illegal_o;

  modport slave (
    input  in_valid_i, instr_i, rs_data_i, rt_data_i,
    output in_ready_o,
    output alu_src1_o, alu_src2_o, alu_ctrl_o,
    input  alu_result_i, alu_zero_i,
    output out_valid_o, out_result_o, out_zero_o, out_ctrl_o, out_illegal_o,
    input  out_ready_i
  );

  modport master (
    output in_valid_i, instr_i, rs_data_i, rt_data_i,
    input  in_ready_o,
    input  alu_src1_o, alu_src2_o, alu_ctrl_o,
    output alu_result_i, alu_zero_i,
    input  out_valid_o, out_result_o, out_zero_o, out_ctrl_o, out_illegal_o,
    output out_ready_i
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Issue/decode stage for the ALU slot.
//
// Operation:
//   - Accepts a MIPS instruction and its register operands.
//   - Decodes them into a 5-bit ALU op code and an operand pair.
//   - Holds the op code and operands on registered outputs for one execute cycle.
//   - Captures the ALU result and zero flag.
//   - Offers the captured values downstream until they are taken.
//
// Ports:
//   clk_i  - clock; all state changes on the rising edge
//   rst_i  - asynchronous, active-low reset
//   bus    - alu_issue_ctrl_if.slave (upstream handshake, ALU bus, downstream handshake)
module alu_issue_ctrl (
  input  logic                clk_i,
  input  logic                rst_i,
  alu_issue_ctrl_if.slave     bus
);

  localparam logic [4:0] OP_NOTH = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_ADDU = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_OR   = 5'd5;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_NOR  = 5'd7;
  localparam logic [4:0] OP_SMAL = 5'd9;
  localparam logic [4:0] OP_LEFT = 5'd10;
  localparam logic [4:0] OP_RIGH = 5'd11;
  localparam logic [4:0] OP_RS   = 5'd12;
  localparam logic [4:0] OP_EQUA = 5'd13;
  localparam logic [4:0] OP_NEQU = 5'd14;
  localparam logic [4:0] OP_BIG  = 5'd15;
  localparam logic [4:0] OP_JTYP = 5'd16;
  localparam logic [4:0] OP_LUI  = 5'd17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic        in_ready;
  logic        out_valid;
  logic        accept;
  logic        capture;

  logic [4:0]  dec_ctrl;
  logic [31:0] dec_src1;
  logic [31:0] dec_src2;
  logic        dec_illegal;

  logic [31:0] src1_q;
  logic [31:0] src2_q;
  logic [4:0]  ctrl_q;
  logic        illegal_q;
  logic [31:0] result_q;
  logic        zero_q;
  logic [4:0]  out_ctrl_q;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign opcode   = bus.instr_i[31:26];
  assign funct    = bus.instr_i[5:0];
  assign shamt    = bus.instr_i[10:6];
  assign imm_sext = {{16{bus.instr_i[15]}}, bus.instr_i[15:0]};
  assign imm_zext = {16'h0000, bus.instr_i[15:0]};

  // Instruction decode.
  // Only field selection and immediate extension happen here; all arithmetic
  // is left to the ALU. Anything unrecognised issues as NOTH with zero
  // operands and raises the illegal flag.
  always_comb begin
    dec_ctrl    = OP_NOTH;
    dec_src1    = 32'h0;
    dec_src2    = 32'h0;
    dec_illegal = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin dec_ctrl = OP_ADD;  dec_src1 = bus.rs_data_i; dec_src2 = bus.rt_data_i; end
          6'h21: begin dec_ctrl = OP_ADDU; dec_src1 = bus.rs_data_i; dec_src2 = bus.rt_data_i; end
          6'h22: begin dec_ctrl = OP_SUB;  dec_src1 = bus.rs_data_i; dec_src2 = bus.rt_data_i; end
          6'h24: begin dec_ctrl = OP_AND;  dec_src1 = bus.rs_data_i; dec_src2 = bus.rt_data_i; end
          6'h25: begin dec_ctrl = OP_OR;   dec_src1 = bus.rs_data_i; dec_src2 = bus.rt_data_i; end
          6'h26: begin dec_ctrl = OP_XOR;  dec_src1 = bus.rs_data_i; dec_src2 = bus.rt_data_i; end
          6'h27: begin dec_ctrl = OP_NOR;  dec_src1 = bus.rs_data_i; dec_src2 = bus.rt_data_i; end
          6'h2A: begin dec_ctrl = OP_SMAL; dec_src1 = bus.rs_data_i; dec_src2 = bus.rt_data_i; end
          // Shifts operate on rt; the shift amount rides in src2.
          6'h00: begin dec_ctrl = OP_LEFT; dec_src1 = bus.rt_data_i; dec_src2 = {27'h0, shamt}; end
          6'h02: begin dec_ctrl = OP_RIGH; dec_src1 = bus.rt_data_i; dec_src2 = {27'h0, shamt}; end
          6'h08: begin dec_ctrl = OP_RS;   dec_src1 = bus.rs_data_i; end
          default: dec_illegal = 1'b1;
        endcase
      end
      6'h08: begin dec_ctrl = OP_ADD;  dec_src1 = bus.rs_data_i; dec_src2 = imm_sext; end
      6'h09: begin dec_ctrl = OP_ADDU; dec_src1 = bus.rs_data_i; dec_src2 = imm_sext; end
      6'h0A: begin dec_ctrl = OP_SMAL; dec_src1 = bus.rs_data_i; dec_src2 = imm_sext; end
      // Loads and stores use the ALU only to form the address.
      6'h23, 6'h2B: begin dec_ctrl = OP_ADD; dec_src1 = bus.rs_data_i; dec_src2 = imm_sext; end
      6'h0C: begin dec_ctrl = OP_AND;  dec_src1 = bus.rs_data_i; dec_src2 = imm_zext; end
      6'h0D: begin dec_ctrl = OP_OR;   dec_src1 = bus.rs_data_i; dec_src2 = imm_zext; end
      // The ALU moves the immediate into the upper half itself.
      6'h0F: begin dec_ctrl = OP_LUI;  dec_src2 = imm_zext; end
      6'h04: begin dec_ctrl = OP_EQUA; dec_src1 = bus.rs_data_i; dec_src2 = bus.rt_data_i; end
      6'h05: begin dec_ctrl = OP_NEQU; dec_src1 = bus.rs_data_i; dec_src2 = bus.rt_data_i; end
      6'h07: begin dec_ctrl = OP_BIG;  dec_src1 = bus.rs_data_i; end
      6'h02, 6'h03: dec_ctrl = OP_JTYP;
      default: dec_illegal = 1'b1;
    endcase
  end

  // State register.
  // Reset returns to IDLE immediately, which drops any in-flight operation.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake logic.
  // IDLE accepts a new instruction. EXEC always lasts exactly one cycle while
  // the ALU evaluates. HOLD keeps the result on offer until downstream takes it.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid_i) begin
          accept     = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: begin
        capture    = 1'b1;
        next_state = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (bus.out_ready_i) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Issue registers.
  // These load only on acceptance, so the ALU bus holds the last issued
  // operation through HOLD and IDLE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      src1_q    <= 32'h0;
      src2_q    <= 32'h0;
      ctrl_q    <= OP_NOTH;
      illegal_q <= 1'b0;
    end else if (accept) begin
      src1_q    <= dec_src1;
      src2_q    <= dec_src2;
      ctrl_q    <= dec_ctrl;
      illegal_q <= dec_illegal;
    end
  end

  // Result capture at the end of EXEC.
  // For NOTH the ALU leaves its previous output in place, so that output is
  // discarded and zeros are captured instead.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      result_q   <= 32'h0;
      zero_q     <= 1'b0;
      out_ctrl_q <= OP_NOTH;
    end else if (capture) begin
      out_ctrl_q <= ctrl_q;
      if (ctrl_q == OP_NOTH) begin
        result_q <= 32'h0;
        zero_q   <= 1'b0;
      end else begin
        result_q <= bus.alu_result_i;
        zero_q   <= bus.alu_zero_i;
      end
    end
  end

  assign bus.in_ready_o    = in_ready;
  assign bus.out_valid_o   = out_valid;
  assign bus.alu_src1_o    = src1_q;
  assign bus.alu_src2_o    = src2_q;
  assign bus.alu_ctrl_o    = ctrl_q;
  assign bus.out_result_o  = result_q;
  assign bus.out_zero_o    = zero_q;
  assign bus.out_ctrl_o    = out_ctrl_q;
  assign bus.out_illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
// Directed bench for alu_issue_ctrl.
// A small behavioural ALU answers on the ALU bus. For NOTH it deliberately
// returns junk, so the stage's forced-zero capture is observable.
module tb_alu_issue_ctrl;

  logic clk_i;
  logic rst_i;
  int   checks;
  int   failures;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Behavioural ALU, combinational from the issued op code and operands.
  logic [31:0] alu_res;
  logic        alu_zero;
  logic [31:0] a;
  logic [31:0] b;

  always_comb begin
    a        = bus.alu_src1_o;
    b        = bus.alu_src2_o;
    alu_res  = 32'h0;
    alu_zero = 1'b0;
    case (bus.alu_ctrl_o)
      5'd1, 5'd2: alu_res = a + b;
      5'd3:       alu_res = a - b;
      5'd4:       alu_res = a & b;
      5'd5:       alu_res = a | b;
      5'd6:       alu_res = a ^ b;
      5'd7:       alu_res = ~(a | b);
      5'd8:       alu_res = ~(a & b);
      5'd9:       alu_res = {31'h0, $signed(a) < $signed(b)};
      5'd10:      alu_res = a << b[4:0];
      5'd11:      alu_res = a >> b[4:0];
      5'd12:      alu_res = a;
      5'd13, 5'd14: alu_res = a - b;
      5'd15:      alu_res = a;
      5'd16:      alu_res = 32'h0;
      5'd17:      alu_res = b << 16;
      default:    alu_res = 32'hDEADBEEF;
    endcase
    case (bus.alu_ctrl_o)
      5'd13:   alu_zero = (a == b);
      5'd14:   alu_zero = (a != b);
      5'd15:   alu_zero = ($signed(a) > 0);
      5'd0:    alu_zero = 1'b1;
      default: alu_zero = (alu_res == 32'h0);
    endcase
  end

  assign bus.alu_result_i = alu_res;
  assign bus.alu_zero_i   = alu_zero;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issues one instruction and checks it through issue, result and handoff.
  // Called #1 after a rising edge. The expected values are hand-computed.
  task automatic applyStimulus(input string tag, input logic [31:0] instr,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [4:0] exp_ctrl, input logic [31:0] exp_src1,
                               input logic [31:0] exp_src2, input logic [31:0] exp_result,
                               input logic exp_zero, input logic exp_illegal);
    int waited;
    bus.instr_i    = instr;
    bus.rs_data_i  = rs;
    bus.rt_data_i  = rt;
    bus.in_valid_i = 1'b1;
    waited = 0;
    while (!bus.in_ready_o && waited < 10) begin
      @(posedge clk_i); #1;
      waited++;
    end
    if (waited >= 10) checkOutput({tag, ".ready_timeout"}, 32'(bus.in_ready_o), 32'd1);
    @(posedge clk_i); #1;
    bus.in_valid_i = 1'b0;
    checkOutput({tag, ".ctrl"}, 32'(bus.alu_ctrl_o), 32'(exp_ctrl));
    checkOutput({tag, ".src1"}, bus.alu_src1_o, exp_src1);
    checkOutput({tag, ".src2"}, bus.alu_src2_o, exp_src2);
    checkOutput({tag, ".exec_valid"}, 32'(bus.out_valid_o), 32'd0);
    @(posedge clk_i); #1;
    checkOutput({tag, ".out_valid"}, 32'(bus.out_valid_o), 32'd1);
    checkOutput({tag, ".result"}, bus.out_result_o, exp_result);
    checkOutput({tag, ".zero"}, 32'(bus.out_zero_o), 32'(exp_zero));
    checkOutput({tag, ".out_ctrl"}, 32'(bus.out_ctrl_o), 32'(exp_ctrl));
    checkOutput({tag, ".illegal"}, 32'(bus.out_illegal_o), 32'(exp_illegal));
    bus.out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    bus.out_ready_i = 1'b0;
    checkOutput({tag, ".drained"}, 32'(bus.out_valid_o), 32'd0);
    checkOutput({tag, ".ready_again"}, 32'(bus.in_ready_o), 32'd1);
  endtask

  // Checks that every output is back at its reset value.
  task automatic checkResetState(input string tag);
    checkOutput({tag, ".in_ready"}, 32'(bus.in_ready_o), 32'd1);
    checkOutput({tag, ".out_valid"}, 32'(bus.out_valid_o), 32'd0);
    checkOutput({tag, ".alu_ctrl"}, 32'(bus.alu_ctrl_o), 32'd0);
    checkOutput({tag, ".alu_src1"}, bus.alu_src1_o, 32'd0);
    checkOutput({tag, ".alu_src2"}, bus.alu_src2_o, 32'd0);
    checkOutput({tag, ".out_result"}, bus.out_result_o, 32'd0);
    checkOutput({tag, ".out_ctrl"}, 32'(bus.out_ctrl_o), 32'd0);
    checkOutput({tag, ".out_zero"}, 32'(bus.out_zero_o), 32'd0);
    checkOutput({tag, ".out_illegal"}, 32'(bus.out_illegal_o), 32'd0);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst_i           = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.instr_i     = 32'h0;
    bus.rs_data_i   = 32'h0;
    bus.rt_data_i   = 32'h0;

    // While reset is held, an offered add must be ignored.
    #1;
    bus.instr_i    = 32'h00851020;
    bus.rs_data_i  = 32'd5;
    bus.rt_data_i  = 32'd7;
    bus.in_valid_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checkResetState("reset");
    bus.in_valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    $display("[TB] directed decode vectors");
    applyStimulus("add",  32'h00851020, 32'd5, 32'd7, 5'd1, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    applyStimulus("addi", 32'h2022FFFF, 32'd3, 32'd0, 5'd1, 32'd3, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
    applyStimulus("ori",  32'h3422FFFF, 32'd0, 32'd0, 5'd5, 32'd0, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0);
    applyStimulus("beq",  32'h10220003, 32'd9, 32'd9, 5'd13, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
    applyStimulus("bne",  32'h14220003, 32'd9, 32'd9, 5'd14, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0);
    applyStimulus("bgtz", 32'h1C200003, 32'hFFFFFFFF, 32'd0, 5'd15, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
    applyStimulus("sll",  32'h00021900, 32'd0, 32'd1, 5'd10, 32'd1, 32'd4, 32'd16, 1'b0, 1'b0);
    applyStimulus("lui",  32'h3C011234, 32'd0, 32'd0, 5'd17, 32'd0, 32'h00001234, 32'h12340000, 1'b0, 1'b0);
    applyStimulus("add2", 32'h00851020, 32'd5, 32'd7, 5'd1, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    applyStimulus("ill",  32'hFC000000, 32'd5, 32'd7, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);

    // Back-pressure: out_ready_i stays low through five HOLD cycles while a
    // competing instruction is offered upstream.
    $display("[TB] hold and mid-flight reset");
    bus.instr_i    = 32'h00851020;
    bus.rs_data_i  = 32'd5;
    bus.rt_data_i  = 32'd7;
    bus.in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    bus.instr_i    = 32'h3C011234;
    @(posedge clk_i); #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold.out_valid", 32'(bus.out_valid_o), 32'd1);
      checkOutput("hold.in_ready", 32'(bus.in_ready_o), 32'd0);
      checkOutput("hold.result", bus.out_result_o, 32'd12);
      checkOutput("hold.alu_ctrl", 32'(bus.alu_ctrl_o), 32'd1);
      @(posedge clk_i); #1;
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    bus.out_ready_i = 1'b0;
    checkOutput("hold.released", 32'(bus.in_ready_o), 32'd1);

    // Accept the lui, then assert reset during its EXEC cycle.
    bus.in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    bus.in_valid_i = 1'b0;
    checkOutput("midrst.exec_ctrl", 32'(bus.alu_ctrl_o), 32'd17);
    rst_i = 1'b0;
    #1;
    checkResetState("midrst");
    #2;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("midrst.after_valid", 32'(bus.out_valid_o), 32'd0);
    checkOutput("midrst.after_ready", 32'(bus.in_ready_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
